inst_mem_ctrl: RTL and testbench

//   Parametrised, loadable instruction memory for the MIPS fetch stage.
//   - Program image is written word-by-word through a programming port.
//   - Fetches are pipelined, with a req/ready handshake and fixed READ_LAT latency.
//   - Misaligned or out-of-range fetches are flagged and return NOP_WORD.
//   - Delivery of HALT_WORD stops fetching until the memory is reloaded or restarted.

---
 rtl/inst_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_inst_mem_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_ctrl.sv
// Loadable instruction memory for the MIPS fetch stage: word programming port,
// pipelined fixed-latency fetch with fault flagging, and HALT-word detection.
module inst_mem_ctrl #(
  parameter int                    DEPTH      = 64,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    READ_LAT   = 1,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hB4221820,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000020,
  localparam int                   PAW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int                   CNTW       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_en,
  input  logic                  prog_we,
  input  logic [PAW-1:0]        prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic                  prog_err,
  output logic [CNTW-1:0]       load_count,
  input  logic                  run_start,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic                  inst_fault,
  output logic                  halt_seen
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALTED} state_t;

  localparam logic [PAW:0]          DEPTH_P = (PAW + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [CNTW-1:0]       CNT_MAX = CNTW'(DEPTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  enter_load, enter_run, halt_now, halt_q;
  logic                  wr_ok, wr_en, accept, flt_rd;
  logic [PAW-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  vld_p0, flt_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  vld_out, flt_out;
  logic [DATA_WIDTH-1:0] data_out;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNTW'(1);
  endfunction

  function automatic logic fetch_faults(input logic [ADDR_WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH_A);
  endfunction

  assign fetch_ready = (state_q == RUN);
  assign accept      = fetch_req & fetch_ready;
  assign rd_idx      = fetch_addr[PAW+1:2];
  assign flt_rd      = fetch_faults(fetch_addr);
  assign rd_word     = flt_rd ? NOP_WORD : mem[rd_idx];
  assign wr_ok       = ({1'b0, prog_addr} < DEPTH_P);
  assign wr_en       = (state_q == LOAD) & prog_we;

  // HALT is recognised on delivery, so the sticky flag shows in the same cycle
  assign halt_now  = (state_q == RUN) & inst_valid & ~inst_fault & (inst_out == HALT_WORD);
  assign halt_seen = halt_q | halt_now;

  always_comb begin
    state_d    = state_q;
    enter_load = 1'b0;
    enter_run  = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (prog_en) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end else if (run_start) begin
          state_d   = RUN;
          enter_run = 1'b1;
        end
      end
      LOAD:    if (!prog_en) state_d = IDLE;
      RUN:     if (halt_now) state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prog_err   <= 1'b0;
      load_count <= '0;
      halt_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enter_load) begin
        load_count <= '0;
        prog_err   <= 1'b0;
      end else if (wr_en) begin
        if (wr_ok) load_count <= sat_inc(load_count);
        else       prog_err   <= 1'b1;
      end
      if (enter_run)     halt_q <= 1'b0;
      else if (halt_now) halt_q <= 1'b1;
    end
  end

  // Array is deliberately not reset so a program survives a reset
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[prog_addr] <= prog_data;
  end

  // Stage p0: memory sampled at accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      flt_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        data_p0 <= rd_word;
        flt_p0  <= flt_rd;
      end
    end
  end

  if (READ_LAT == 1) begin : g_lat1
    assign vld_out  = vld_p0;
    assign flt_out  = flt_p0;
    assign data_out = data_p0;
  end else begin : g_lat2
    logic                  vld_p1, flt_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    // Stage p1: extra register for two-cycle latency, holds between pulses
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_p1  <= 1'b0;
        flt_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) begin
          data_p1 <= data_p0;
          flt_p1  <= flt_p0;
        end
      end
    end

    assign vld_out  = vld_p1;
    assign flt_out  = flt_p1;
    assign data_out = data_p1;
  end

  assign inst_valid = vld_out;
  assign inst_out   = data_out;
  assign inst_fault = flt_out & vld_out;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Randomized bench for inst_mem_ctrl: a transaction-level model (memory array,
// delivery queue, mode tracking) predicts every output each cycle.
module tb_inst_mem_ctrl;
  localparam int          DEPTH = 48;
  localparam int          LAT   = 2;
  localparam int          PAW   = $clog2(DEPTH);
  localparam int          CNTW  = $clog2(DEPTH + 1);
  localparam logic [31:0] HALT  = 32'hB4221820;
  localparam logic [31:0] NOP   = 32'h00000020;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            prog_en, prog_we, run_start, fetch_req;
  logic [PAW-1:0]  prog_addr;
  logic [31:0]     prog_data, fetch_addr;
  logic            prog_err, fetch_ready, inst_valid, inst_fault, halt_seen;
  logic [CNTW-1:0] load_count;
  logic [31:0]     inst_out;

  always #5 clk = ~clk;

  inst_mem_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LAT(LAT),
                  .HALT_WORD(HALT), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .prog_en(prog_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_err(prog_err),
    .load_count(load_count), .run_start(run_start), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_ready(fetch_ready), .inst_valid(inst_valid),
    .inst_out(inst_out), .inst_fault(inst_fault), .halt_seen(halt_seen)
  );

  typedef enum {M_IDLE, M_LOAD, M_RUN, M_HALTED} mode_t;
  typedef struct {int due; logic [31:0] word; logic flt;} pend_t;

  int          checks = 0;
  int          errors = 0;
  mode_t       mode;
  logic [31:0] m_mem [DEPTH];
  pend_t       pend_q [$];
  int          edges;
  logic        cur_vld, cur_flt, halt_exp, exp_err;
  logic [31:0] cur_word;
  int          exp_cnt;
  logic [31:0] prog_words [3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic idle_inputs();
    prog_en = 0; prog_we = 0; run_start = 0; fetch_req = 0;
    prog_addr = '0; prog_data = '0; fetch_addr = '0;
  endtask

  // One clock: apply the rules to the current inputs, advance, then compare.
  task automatic tick();
    logic  f;
    logic  [31:0] w;
    pend_t p;
    if (fetch_req && mode == M_RUN) begin
      f = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> 2) >= DEPTH);
      if (f) w = NOP;
      else   w = m_mem[fetch_addr >> 2];
      pend_q.push_back('{due: edges + LAT, word: w, flt: f});
    end
    if (mode == M_LOAD && prog_we) begin
      if (prog_addr < DEPTH) begin
        m_mem[prog_addr] = prog_data;
        if (exp_cnt < DEPTH) exp_cnt++;
      end else begin
        exp_err = 1'b1;
      end
    end
    case (mode)
      M_IDLE, M_HALTED: begin
        if (prog_en) begin
          mode = M_LOAD; exp_cnt = 0; exp_err = 1'b0;
        end else if (run_start) begin
          mode = M_RUN; halt_exp = 1'b0;
        end
      end
      M_LOAD:  if (!prog_en) mode = M_IDLE;
      M_RUN:   if (cur_vld && !cur_flt && cur_word == HALT) mode = M_HALTED;
      default: ;
    endcase

    @(posedge clk);
    edges++;
    cur_vld = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due == edges) begin
      p = pend_q.pop_front();
      cur_vld = 1'b1; cur_word = p.word; cur_flt = p.flt;
    end
    if (mode == M_RUN && cur_vld && !cur_flt && cur_word == HALT) halt_exp = 1'b1;

    #1;
    check_eq("inst_valid", inst_valid, cur_vld);
    if (cur_vld) check_eq("inst_fault", inst_fault, cur_flt);
    check_eq("inst_out", inst_out, cur_word);
    check_eq("fetch_ready", fetch_ready, mode == M_RUN);
    check_eq("halt_seen", halt_seen, halt_exp);
    check_eq("load_count", load_count, exp_cnt);
    check_eq("prog_err", prog_err, exp_err);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    mode = M_IDLE; pend_q.delete(); cur_vld = 0; cur_flt = 0; cur_word = '0;
    halt_exp = 0; exp_err = 0; exp_cnt = 0;
    check_eq("rst_fetch_ready", fetch_ready, 1'b0);
    check_eq("rst_inst_valid", inst_valid, 1'b0);
    check_eq("rst_inst_fault", inst_fault, 1'b0);
    check_eq("rst_halt_seen", halt_seen, 1'b0);
    check_eq("rst_prog_err", prog_err, 1'b0);
    check_eq("rst_inst_out", inst_out, 32'h0);
    check_eq("rst_load_count", load_count, 32'h0);
    @(posedge clk); edges++;
    @(posedge clk); edges++;
    #2 reset = 1'b1;
  endtask

  task automatic fetch_seq(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    fetch_req = 1;
    fetch_addr = a0; tick();
    fetch_addr = a1; tick();
    fetch_addr = a2; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    edges = 0;
    prog_words[0] = 32'h8C010000;
    prog_words[1] = 32'h20010002;
    prog_words[2] = HALT;
    idle_inputs();
    do_reset();

    // IDLE ignores fetch requests
    fetch_req = 1;
    repeat (4) begin
      fetch_addr = $urandom_range(0, DEPTH - 1) * 4;
      tick();
    end
    idle_inputs();

    // Full load: program words, DEPTH+1 legal writes, one out-of-range write
    prog_en = 1; tick();
    for (int i = 0; i <= DEPTH; i++) begin
      prog_we   = 1;
      prog_addr = PAW'((i < 3) ? i : ((i == DEPTH) ? 3 : i));
      prog_data = (i < 3) ? prog_words[i] : rand_word();
      tick();
    end
    prog_addr = PAW'($urandom_range(DEPTH, (1 << PAW) - 1));
    prog_data = rand_word();
    tick();
    prog_we = 0; prog_en = 0; tick();

    // Run the three-word program; keep requesting past the HALT delivery
    run_start = 1; tick(); run_start = 0;
    fetch_seq(32'd0, 32'd4, 32'd8);
    repeat (3) begin
      fetch_addr = $urandom_range(3, DEPTH - 1) * 4;
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    // prog_en wins over run_start in HALTED; reload and rerun
    prog_en = 1; run_start = 1; tick(); run_start = 0;
    for (int i = 0; i < 2; i++) begin
      prog_we = 1; prog_addr = PAW'(i); prog_data = rand_word(); tick();
    end
    prog_we = 0; prog_en = 0; tick();
    run_start = 1; tick(); run_start = 0;
    fetch_seq(32'd0, 32'd4, 32'h6);
    fetch_seq(32'(4 * DEPTH), 32'd8, 32'd12);
    idle_inputs();
    repeat (4) tick();

    // Randomized traffic on every input
    for (int i = 0; i < 300; i++) begin
      fetch_req = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       fetch_addr = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
        1:       fetch_addr = $urandom_range(DEPTH, 4000) * 4;
        2:       fetch_addr = 32'd8;
        default: fetch_addr = $urandom_range(0, DEPTH - 1) * 4;
      endcase
      run_start = ($urandom_range(0, 5) == 0);
      prog_en   = ($urandom_range(0, 19) == 0) || (mode == M_LOAD && $urandom_range(0, 1) == 1);
      prog_we   = $urandom_range(0, 1);
      prog_addr = PAW'($urandom_range(0, (1 << PAW) - 1));
      prog_data = rand_word();
      tick();
    end
    idle_inputs();
    repeat (4) tick();

    // Reset between accept and delivery: nothing is delivered afterwards
    run_start = 1; tick(); run_start = 0;
    fetch_req = 1; fetch_addr = 32'd4; tick();
    idle_inputs();
    do_reset();
    repeat (4) tick();

    // Memory contents survive reset
    run_start = 1; tick(); run_start = 0;
    fetch_seq(32'd0, 32'd4, 32'd12);
    fetch_seq(32'd16, 32'd20, 32'd8);
    idle_inputs();
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
